// File: rtl/button_scanner.sv
// rtl/button_scanner.sv - round-robin debouncer for raw button inputs with a press/release event queue
//
// Purpose: each raw input is synchronised, then a single scan engine visits one
// channel per cycle and runs that channel's debounce counter. When a counter
// saturates and the input still differs, the debounced level flips and an event
// is pushed into a small FIFO read through a valid/ready handshake.
//
// Optional feature: define BUTTON_SCANNER_AUTOREPEAT_EN to add per-channel
// auto-repeat events while a button stays pressed. Without it, there is no repeat
// storage and evt_repeat is tied to 0.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   in          raw asynchronous inputs, 1 = pressed
//   state       debounced level per channel
//   evt_valid   event queue non-empty
//   evt_ready   consumer pops the head when evt_valid & evt_ready
//   evt_press   head event: 1 = press, 0 = release
//   evt_repeat  head event is an auto-repeat
//   evt_index   head event channel number
//   overflow    sticky: an event was dropped because the queue was full

module button_scanner #(
    parameter int NUM_INPUTS   = 7,
    parameter int COUNT_WIDTH  = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         in,
    output logic [NUM_INPUTS-1:0]         state,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          evt_press,
    output logic                          evt_repeat,
    output logic [$clog2(NUM_INPUTS)-1:0] evt_index,
    output logic                          overflow
);

    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
`ifdef BUTTON_SCANNER_AUTOREPEAT_EN
    localparam int EW = IDX_W + 2;   // {press, repeat, index}
`else
    localparam int EW = IDX_W + 1;   // {press, index}
`endif

    logic [NUM_INPUTS-1:0]  sync1_q, sync2_q;
    logic [NUM_INPUTS-1:0]  state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] cnt_q [NUM_INPUTS];
    logic [COUNT_WIDTH-1:0] cnt_d;
    logic                   vis_sync, vis_state;
    logic                   push;
    logic [EW-1:0]          push_entry;
`ifdef BUTTON_SCANNER_AUTOREPEAT_EN
    logic [REPEAT_WIDTH-1:0] rpt_q [NUM_INPUTS];
    logic [REPEAT_WIDTH-1:0] rpt_d;
    logic                    push_repeat;
`endif

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          overflow_q;
    logic          empty, full, pop, wr_en;
    logic [EW-1:0] head;

    // Scan engine: only the channel under idx_q is evaluated this cycle.
    always_comb begin
        vis_sync  = sync2_q[idx_q];
        vis_state = state_q[idx_q];
        state_d   = state_q;
        cnt_d     = '0;
        push      = 1'b0;
        idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        if (vis_sync != vis_state) begin
            if (cnt_q[idx_q] != '1) begin
                cnt_d = cnt_q[idx_q] + 1'b1;
            end else begin
                state_d[idx_q] = vis_sync;
                push           = 1'b1;
            end
        end
`ifdef BUTTON_SCANNER_AUTOREPEAT_EN
        // A commit needs sync != state, a repeat needs both high, so the two
        // never collide and the repeat counter is already cleared on commits.
        rpt_d       = '0;
        push_repeat = 1'b0;
        if (vis_sync && vis_state) begin
            if (rpt_q[idx_q] == '1) begin
                push        = 1'b1;
                push_repeat = 1'b1;
            end else begin
                rpt_d = rpt_q[idx_q] + 1'b1;
            end
        end
        push_entry = {vis_sync, push_repeat, idx_q};
`else
        push_entry = {vis_sync, idx_q};
`endif
    end

    // Full/empty from pointers carrying one extra wrap bit.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && evt_ready;
    // A pop frees the head slot on the same edge, so a push into a full queue
    // is still accepted when a pop accompanies it.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= '0;
            idx_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
`ifdef BUTTON_SCANNER_AUTOREPEAT_EN
                rpt_q[i] <= '0;
`endif
            end
        end else begin
            sync1_q      <= in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q[idx_q] <= cnt_d;
`ifdef BUTTON_SCANNER_AUTOREPEAT_EN
            rpt_q[idx_q] <= rpt_d;
`endif
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= push_entry;
            end
            wr_q <= wr_q + {{AW{1'b0}}, wr_en};
            rd_q <= rd_q + {{AW{1'b0}}, pop};
            if (push && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign head      = mem_q[rd_q[AW-1:0]];
    // The event outputs are forced low while reset is asserted, not just after it.
    assign evt_valid = !reset && !empty;
    assign evt_press = evt_valid && head[EW-1];
    assign evt_index = evt_valid ? head[IDX_W-1:0] : '0;
`ifdef BUTTON_SCANNER_AUTOREPEAT_EN
    assign evt_repeat = evt_valid && head[IDX_W];
`else
    assign evt_repeat = 1'b0;
`endif
    assign state    = state_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_button_scanner.sv
// tb/tb_button_scanner.sv - directed self-checking bench for button_scanner

module tb_button_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] raw;
    logic [2:0] state;
    logic       evt_valid, evt_ready, evt_press, evt_repeat, overflow;
    logic [1:0] evt_index;
    int         total = 0;
    int         bad   = 0;

    button_scanner #(
        .NUM_INPUTS(3), .COUNT_WIDTH(2), .FIFO_DEPTH(2), .REPEAT_WIDTH(3)
    ) dut (
        .clk(clk), .reset(reset), .in(raw), .state(state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_press(evt_press),
        .evt_repeat(evt_repeat), .evt_index(evt_index), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge just before the first scanning edge (P0).
    task automatic do_reset(input logic [2:0] hold);
        raw       = hold;
        reset     = 1'b1;
        evt_ready = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    initial begin
        raw = '0; reset = 1'b1; evt_ready = 1'b0;
        tick(3);
        check_eq("reset_state", state, 3'b000);
        check_eq("reset_valid", evt_valid, 0);
        check_eq("reset_ovf", overflow, 0);

        // Single press on channel 1: first differing visit P4, commit P13.
        reset = 1'b0; raw = 3'b010;
        tick(13);
        check_eq("t1_state_pre", state, 3'b000);
        check_eq("t1_valid_pre", evt_valid, 0);
        tick(1);
        check_eq("t1_state", state, 3'b010);
        check_eq("t1_valid", evt_valid, 1);
        check_eq("t1_press", evt_press, 1);
        check_eq("t1_index", evt_index, 1);
        check_eq("t1_repeat", evt_repeat, 0);
        pop_one();
        check_eq("t1_popped", evt_valid, 0);
        tick(20);
        check_eq("t1_single", evt_valid, 0);

        // Short glitch is discarded.
        do_reset(3'b000);
        raw = 3'b010;
        tick(5);
        raw = 3'b000;
        tick(40);
        check_eq("t2_state", state, 3'b000);
        check_eq("t2_valid", evt_valid, 0);

        // Three presses into a depth-2 queue: third is dropped.
        do_reset(3'b001);
        tick(6);  raw = 3'b011;
        tick(6);  raw = 3'b111;
        tick(40);
        check_eq("t3_state", state, 3'b111);
        check_eq("t3_ovf", overflow, 1);
        check_eq("t3_head0", evt_index, 0);
        check_eq("t3_press0", evt_press, 1);
        pop_one();
        check_eq("t3_valid1", evt_valid, 1);
        check_eq("t3_head1", evt_index, 1);
        pop_one();
        check_eq("t3_empty", evt_valid, 0);
        check_eq("t3_ovf_sticky", overflow, 1);

        // Full queue with a commit (ch2 at P23) on the same edge as a pop.
        do_reset(3'b001);
        tick(6);  raw = 3'b011;
        tick(6);  raw = 3'b111;
        tick(11);
        check_eq("t4_full_valid", evt_valid, 1);
        check_eq("t4_full_head", evt_index, 0);
        check_eq("t4_state_pre", state, 3'b011);
        pop_one();
        check_eq("t4_valid", evt_valid, 1);
        check_eq("t4_head", evt_index, 1);
        check_eq("t4_ovf", overflow, 0);
        check_eq("t4_state", state, 3'b111);
        pop_one();
        check_eq("t4_tail", evt_index, 2);
        check_eq("t4_tail_press", evt_press, 1);
        pop_one();
        check_eq("t4_empty", evt_valid, 0);
        check_eq("t4_ovf_end", overflow, 0);

        // Queue a release, then reset with ch2 held: no stale event survives.
        raw = 3'b110;
        tick(20);
        check_eq("t5_rel_valid", evt_valid, 1);
        check_eq("t5_rel_press", evt_press, 0);
        check_eq("t5_rel_index", evt_index, 0);
        raw = 3'b100; reset = 1'b1;
        tick(3);
        check_eq("t5_rst_state", state, 3'b000);
        check_eq("t5_rst_valid", evt_valid, 0);
        reset = 1'b0;
        tick(11);
        check_eq("t5_pre_state", state, 3'b000);
        check_eq("t5_pre_valid", evt_valid, 0);
        tick(1);
        check_eq("t5_state", state, 3'b100);
        check_eq("t5_valid", evt_valid, 1);
        check_eq("t5_index", evt_index, 2);
        check_eq("t5_press", evt_press, 1);
        pop_one();
        check_eq("t5_empty", evt_valid, 0);

`ifdef BUTTON_SCANNER_AUTOREPEAT_EN
        // Ch0 commits at P12, first repeat 24 cycles later at P36.
        do_reset(3'b001);
        tick(13);
        check_eq("t6_press", evt_press, 1);
        check_eq("t6_press_rpt", evt_repeat, 0);
        pop_one();
        tick(22);
        check_eq("t6_pre_rpt", evt_valid, 0);
        tick(1);
        check_eq("t6_rpt_valid", evt_valid, 1);
        check_eq("t6_rpt_flag", evt_repeat, 1);
        check_eq("t6_rpt_index", evt_index, 0);
        pop_one();
        raw = 3'b000;
        tick(20);
        check_eq("t6_rel_press", evt_press, 0);
        check_eq("t6_rel_rpt", evt_repeat, 0);
        pop_one();
        tick(60);
        check_eq("t6_no_rpt", evt_valid, 0);
`else
        // Held press produces no further events without auto-repeat.
        do_reset(3'b001);
        tick(13);
        check_eq("t6_press", evt_press, 1);
        pop_one();
        tick(60);
        check_eq("t6_no_rpt", evt_valid, 0);
        check_eq("t6_rpt_flag", evt_repeat, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
